// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
// Byte stream handshake into the UART transmitter FIFO.
//   s_data  : byte to enqueue (master -> slave)
//   s_valid : s_data is valid (master -> slave)
//   s_ready : FIFO can accept a byte (slave -> master)
// A byte transfers on every clock edge where s_valid && s_ready.
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter with a byte FIFO, runtime frame format (5-8 data bits,
// optional parity, 1/2 stop bits) and a runtime baud divisor. CTS is only
// honoured at frame boundaries.
//
// Build option: define UART_TX_PARITY_EN to include the PARITY state and
// parity generation; otherwise cfg_parity is ignored (frames are 1+N+S bits).
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   s_if (slave)   : s_data / s_valid / s_ready byte input
//   cfg_baud_div   : bit period = cfg_baud_div+1 clocks
//   cfg_data_bits  : 00=5 .. 11=8 data bits
//   cfg_parity     : 01=even, 10=odd, else none
//   cfg_stop2      : two stop bits
//   uart_cts_n     : clear to send, active low
//   uart_tx        : serial line (registered, idles high)
//   tx_busy        : frame in progress
//   tx_done        : one-cycle pulse after the final stop bit
//   fifo_level     : FIFO occupancy
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    uart_tx_fifo_if.slave                 s_if,
    input  logic [DIV_W-1:0]              cfg_baud_div,
    input  logic [1:0]                    cfg_data_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic                          uart_cts_n,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    // ---------------- FIFO ----------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          push, pop, fifo_empty;
    logic [7:0]    head;

    assign s_if.s_ready = (level_q != LW'(FIFO_DEPTH));
    assign push         = s_if.s_valid && s_if.s_ready;
    assign fifo_empty   = (level_q == '0);
    assign head         = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_if.s_data;
    end

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // ---------------- Transmitter FSM ----------------
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       dbits_q, dbits_d;
    logic             stop2_q, stop2_d;
    logic [2:0]       bit_q, bit_d;
    logic             stop_q, stop_d;      // set while in the 2nd stop bit
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             tick, can_start, launch;

`ifdef UART_TX_PARITY_EN
    logic             par_en_q, par_en_d;
    logic             par_bit_q, par_bit_d;
    logic [7:0]       data_mask;
    // Keep only the N data bits that will be sent so upper bits do not
    // leak into the parity.
    assign data_mask = 8'hFF >> (2'd3 - cfg_data_bits);
`else
    logic             unused_parity;
    assign unused_parity = ^cfg_parity;
`endif

    assign tick      = (cnt_q == div_q);
    assign can_start = !fifo_empty && !uart_cts_n;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        dbits_d  = dbits_q;
        stop2_d  = stop2_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        shreg_d  = shreg_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        pop      = 1'b0;
        launch   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif
        case (state_q)
            S_IDLE: launch = can_start;
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shreg_q[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    // N-1 == {1, cfg_data_bits}
                    if (bit_q == {1'b1, dbits_q}) begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else
`endif
                        begin
                            state_d = S_STOP;
                            stop_d  = 1'b0;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (stop2_q && !stop_q) begin
                        stop_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (can_start) launch  = 1'b1;
                        else           state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame start: pop the head byte and freeze the config for the frame.
        if (launch) begin
            state_d = S_START;
            pop     = 1'b1;
            shreg_d = head;
            tx_d    = 1'b0;
            div_d   = cfg_baud_div;
            dbits_d = cfg_data_bits;
            stop2_d = cfg_stop2;
`ifdef UART_TX_PARITY_EN
            par_en_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            par_bit_d = (^(head & data_mask)) ^ (cfg_parity == 2'b10);
`endif
        end

        // Bit timer restarts on every state change and after every tick.
        if (state_q == S_IDLE || tick || state_d != state_q) cnt_d = '0;
        else                                                cnt_d = cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            dbits_q <= '0;
            stop2_q <= 1'b0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            dbits_q <= dbits_d;
            stop2_q <= stop2_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end
`endif

    assign uart_tx    = tx_q;
    assign tx_busy    = (state_q != S_IDLE);
    assign tx_done    = done_q;
    assign fifo_level = level_q;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised next-generation UART transmitter for the UART-AXI4 bridge. It adds a byte FIFO with a valid/ready input, runtime-selectable frame format (5–8 data bits, optional parity, 1 or 2 stop bits) and a runtime baud divisor. CTS flow control is applied only at frame boundaries. It sits between the bridge response path and the UART TX pin.

## Interface
Parameters:
- `FIFO_DEPTH`, default 16. FIFO entries; power of two, ≥2.
- `DIV_W`, default 16. Width of the baud divisor.

Ports:
- `clk` in 1. Single clock.
- `rst_n` in 1. Asynchronous, active-low reset.
- `s_data` in 8. Byte to enqueue.
- `s_valid` in 1. `s_data` is valid.
- `s_ready` out 1. FIFO can accept a byte.
- `cfg_baud_div` in DIV_W. Bit period is `cfg_baud_div`+1 clocks.
- `cfg_data_bits` in 2. 00=5, 01=6, 10=7, 11=8 data bits.
- `cfg_parity` in 2. 00=none, 01=even, 10=odd, 11=none.
- `cfg_stop2` in 1. 1 selects two stop bits.
- `uart_cts_n` in 1. Clear to send, active low.
- `uart_tx` out 1. Serial line.
- `tx_busy` out 1. A frame is in progress.
- `tx_done` out 1. One-cycle pulse at frame end.
- `fifo_level` out $clog2(FIFO_DEPTH)+1. Current FIFO occupancy.

## Operation
- **FIFO**
  - Push when `s_valid && s_ready`. `s_ready = (fifo_level != FIFO_DEPTH)`.
  - Pop happens only on frame start.
  - A push and a pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **States:** IDLE, START, DATA, PARITY, STOP.
- **IDLE → START** when the FIFO is non-empty and `uart_cts_n`=0.
  - The head byte is popped into the shift register.
  - `cfg_*` is latched into frame registers. Config changes mid-frame do not affect the current frame.
- **Bit timer**
  - Counts 0..latched_div. A tick occurs at latched_div. The timer resets on every state change.
  - Divisor 0 gives a 1-clock bit.
- **START:** `uart_tx`=0 for one bit period, then DATA.
- **DATA:**
  - Shift out LSB first, one bit per period.
  - After the Nth bit (N=5..8), go to PARITY if parity is enabled, else STOP.
- **PARITY:** one bit.
  - Even: XOR of the N transmitted bits.
  - Odd: its inverse.
  - Bits above N do not contribute.
- **STOP:** `uart_tx`=1 for 1 or 2 bit periods. On the final tick:
  - Pulse `tx_done`.
  - If the FIFO is non-empty and CTS is low, go directly to START (no idle gap).
  - Otherwise go to IDLE.
- **CTS**
  - CTS is sampled only at the IDLE/STOP-end decision points.
  - Deasserting CTS mid-frame never truncates the frame.
- `tx_busy` = (state != IDLE).

## Timing
- **Reset values:** `uart_tx`=1, `tx_busy`=0, `tx_done`=0, `s_ready`=1, `fifo_level`=0. The FIFO is emptied and the state is IDLE.
- `uart_tx` is a registered output. Reset asserted mid-frame drives the line high asynchronously.
- **Start latency:** a byte accepted at edge N into an empty FIFO, with CTS low, drives `uart_tx` low from edge N+1.
- **Frame length:** (1 + N + P + S) × (div+1) clocks, where P∈{0,1} and S∈{1,2}.
- **`tx_done` timing:** asserted for exactly the one cycle after the final stop tick, coincident with state leaving STOP.
- **Back-to-back frames:** the next start bit begins on the same edge that `tx_done` rises.
- **`fifo_level` timing:**
  - Updates on the edge after a push or pop.
  - `s_ready` deasserts on the edge the level reaches `FIFO_DEPTH`.

## Configuration
- **Macro:** `UART_TX_PARITY_EN`.
- **Defined:** the PARITY state and parity generation exist, as described in Operation.
- **Undefined:**
  - `cfg_parity` is ignored and treated as 00.
  - The PARITY state and its logic are not synthesised.
  - Frames are always (1 + N + S) bits.

## Test plan
- **8N1 byte:** div=3, cfg 11/00/0, push 0xA5. `uart_tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks. `tx_done` pulses 40 clocks after the falling edge.
- **7E2 byte:** div=3, push 0x41. Data 1,0,0,0,0,0,1, parity 0, two stop bits. Frame = 44 clocks, one `tx_done` pulse.
- **5O1 byte:** push 0x1F. Data 1,1,1,1,1, parity 0. Bit 5 of `s_data` is ignored.
- **FIFO full and back-to-back:** `FIFO_DEPTH`=4, 5 consecutive `s_valid` cycles with CTS high.
  - `s_ready` drops after the 4th byte; `fifo_level`=4.
  - Then drop CTS: 4 contiguous 8N1 frames, `tx_done` every 40 clocks, no idle gap.
- **CTS mid-frame:** raise `uart_cts_n` during DATA. The frame completes and `tx_done` pulses. The next queued byte waits in IDLE until CTS=0, then starts 1 clock later.
- **Reset mid-frame:** assert `rst_n`=0 during DATA.
  - `uart_tx`=1 immediately; `tx_busy`=0; `fifo_level`=0.
  - After release, the first frame is clean.
  - Repeat 7E1 with `UART_TX_PARITY_EN` undefined: the frame is 9 bits.
